// File: rtl/np_mac_sched_ctrl.sv
// np_mac_sched_ctrl: address/enable sequencer that feeds the FFN MAC and reports bank and pass completion
// Ports:
//   clock_i, reset_i           clock and asynchronous active-high reset
//   start_i, abort_i           begin a pass (IDLE only) / synchronous cancel
//   cfg_last_addr_i/_bank_i    last address and last bank of the pass, latched on start
//   stall_i                    MAC not ready; an issue happens on mult_en_o & ~stall_i
//   addr_o, ram_select_o       operand address and bank select
//   mult_en_o                  addr_o/ram_select_o are valid
//   acc_clear_o, acc_last_o    first / last address of a bank
//   bank_done_o, product_rdy_o pulses when the last product of a bank / pass leaves the MAC
//   busy_o, cfg_err_o          pass in progress / start rejected for a bad bank count
module np_mac_sched_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int NUM_BANKS = 8,
  parameter int RSEL_W    = 3,
  parameter int PIPE_LAT  = 3
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] cfg_last_addr_i,
  input  logic [RSEL_W-1:0] cfg_last_bank_i,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [RSEL_W-1:0] ram_select_o,
  output logic              mult_en_o,
  output logic              acc_clear_o,
  output logic              acc_last_o,
  output logic              bank_done_o,
  output logic              product_rdy_o,
  output logic              busy_o,
  output logic              cfg_err_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [RSEL_W:0]   NB       = (RSEL_W+1)'(NUM_BANKS);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [RSEL_W-1:0] BANK_ONE = RSEL_W'(1);
  localparam logic [PIPE_LAT-1:0] LSB    = PIPE_LAT'(1);
  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, la_q, la_d;
  logic [RSEL_W-1:0]   bank_q, bank_d, lb_q, lb_d;
  logic                mult_en_q, mult_en_d, clr_q, clr_d, last_q, last_d;
  logic                busy_q, busy_d, err_q, err_d;
  logic [PIPE_LAT-1:0] tv_q, tv_d, tb_q, tb_d, tp_q, tp_d;
  logic                issue, a_end, b_end, cfg_bad;
  assign issue   = mult_en_q & ~stall_i;
  assign a_end   = addr_q == la_q;
  assign b_end   = bank_q == lb_q;
  assign cfg_bad = {1'b0, cfg_last_bank_i} >= NB;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    mult_en_d = mult_en_q;
    clr_d     = clr_q;
    last_d    = last_q;
    la_d      = la_q;
    lb_d      = lb_q;
    err_d     = 1'b0;
    if (abort_i) begin
      state_d   = IDLE;
      addr_d    = '0;
      bank_d    = '0;
      mult_en_d = 1'b0;
      clr_d     = 1'b0;
      last_d    = 1'b0;
    end else if (state_q == IDLE && start_i) begin
      if (cfg_bad) begin
        err_d = 1'b1;
      end else begin
        state_d   = RUN;
        addr_d    = '0;
        bank_d    = '0;
        mult_en_d = 1'b1;
        clr_d     = 1'b1;
        last_d    = cfg_last_addr_i == '0;
        la_d      = cfg_last_addr_i;
        lb_d      = cfg_last_bank_i;
      end
    end else if (issue) begin
      if (!a_end) begin
        addr_d = addr_q + ADDR_ONE;
        clr_d  = 1'b0;
        last_d = (addr_q + ADDR_ONE) == la_q;
      end else if (!b_end) begin
        addr_d = '0;
        bank_d = bank_q + BANK_ONE;
        clr_d  = 1'b1;
        last_d = la_q == '0;
      end else begin
        state_d   = DRAIN;
        mult_en_d = 1'b0;
        clr_d     = 1'b0;
        last_d    = 1'b0;
      end
    end else if (state_q == DRAIN && product_rdy_o) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    // tag pipe shifts every cycle regardless of stall; abort drops in-flight tags
    tv_d = abort_i ? '0 : (tv_q << 1) | (issue ? LSB : '0);
    tb_d = abort_i ? '0 : (tb_q << 1) | (issue && a_end ? LSB : '0);
    tp_d = abort_i ? '0 : (tp_q << 1) | (issue && a_end && b_end ? LSB : '0);
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bank_q    <= '0;
      la_q      <= '0;
      lb_q      <= '0;
      mult_en_q <= 1'b0;
      clr_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      tv_q      <= '0;
      tb_q      <= '0;
      tp_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      la_q      <= la_d;
      lb_q      <= lb_d;
      mult_en_q <= mult_en_d;
      clr_q     <= clr_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      tv_q      <= tv_d;
      tb_q      <= tb_d;
      tp_q      <= tp_d;
    end
  end
  assign addr_o        = addr_q;
  assign ram_select_o  = bank_q;
  assign mult_en_o     = mult_en_q;
  assign acc_clear_o   = clr_q;
  assign acc_last_o    = last_q;
  assign busy_o        = busy_q;
  assign cfg_err_o     = err_q;
  assign bank_done_o   = tv_q[PIPE_LAT-1] & tb_q[PIPE_LAT-1];
  assign product_rdy_o = tv_q[PIPE_LAT-1] & tp_q[PIPE_LAT-1];
endmodule
